// File: rtl/ffo_pkg.sv
// ffo_pkg: shared definitions for the find-first-one index streamer.
//   N_DEFAULT        default request-mask width
//   N_MAX            widest mask onehot_count_le1 accepts (narrower masks are zero-extended)
//   state_t          streamer FSM states (IDLE, EMIT)
//   onehot_count_le1 true when at most one bit of the mask is set
package ffo_pkg;

    localparam int unsigned N_DEFAULT = 32;
    localparam int unsigned N_MAX     = 256;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Clearing the lowest set bit leaves zero only for masks with at most one bit set.
    function automatic logic onehot_count_le1(input logic [N_MAX-1:0] m);
        return (m & (m - N_MAX'(1))) == '0;
    endfunction

endpackage

// File: rtl/ffo_index_streamer_if.sv
// ffo_index_streamer_if: mask-in / index-out handshake bundle.
//   in_valid, in_mask[0:N-1], in_ready          mask offer (bit 0 = highest priority)
//   out_valid, out_ready                        index beat handshake
//   out_idx[0:IDX_W-1], out_last, out_zero      beat payload (out_idx bit 0 = MSB)
// master drives the mask and out_ready; slave is the streamer.
interface ffo_index_streamer_if
    import ffo_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) ();

    localparam int unsigned IDX_W = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [0:N-1]     in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [0:IDX_W-1] out_idx;
    logic             out_last;
    logic             out_zero;

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero
    );

endinterface

// File: rtl/ffo_prio_enc.sv
// ffo_prio_enc: combinational priority encoder, binary tree of two-input merge nodes.
//   mask[0:N-1]          input, bit 0 has highest priority
//   v                    any bit of mask set
//   idx[0:$clog2(N)-1]   index of the leftmost set bit (bit 0 = MSB); all ones when v=0
module ffo_prio_enc #(
    parameter int unsigned N = 32
) (
    input  logic [0:N-1]          mask,
    output logic                  v,
    output logic [0:$clog2(N)-1]  idx
);

    if (N == 2) begin : g_leaf
        always_comb begin
            v   = mask[0] | mask[1];
            idx = ~mask[0];
        end
    end else begin : g_node
        logic                    v_l, v_r;
        logic [0:$clog2(N)-2]    idx_l, idx_r;

        ffo_prio_enc #(.N(N/2)) u_left (
            .mask (mask[0:N/2-1]),
            .v    (v_l),
            .idx  (idx_l)
        );

        ffo_prio_enc #(.N(N/2)) u_right (
            .mask (mask[N/2:N-1]),
            .v    (v_r),
            .idx  (idx_r)
        );

        // Index MSB says "not in the left half"; low bits come from the winning child.
        always_comb begin
            v   = v_l | v_r;
            idx = {~v_l, (v_l ? idx_l : idx_r)};
        end
    end

endmodule

// File: rtl/ffo_index_streamer.sv
// ffo_index_streamer: walks an N-bit request mask and emits the index of every set
// bit, leftmost first, one beat per cycle; an all-zero mask yields a single beat
// flagged out_zero.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     ffo_index_streamer_if slave (mask in, index beats out)
module ffo_index_streamer
    import ffo_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ffo_index_streamer_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(N);

    state_t           state_q, state_d;
    logic [0:N-1]     rem_q, rem_d;
    logic             zero_q, zero_d;

    logic             enc_v;
    logic [0:IDX_W-1] enc_idx;

    logic             emit;
    logic             last;
    logic             beat;
    logic             ready;
    logic             accept;

    ffo_prio_enc #(.N(N)) u_enc (
        .mask (rem_q),
        .v    (enc_v),
        .idx  (enc_idx)
    );

    always_comb begin
        emit   = (state_q == EMIT);
        last   = emit & (zero_q | onehot_count_le1(N_MAX'(rem_q)));
        beat   = emit & bus.out_ready;
        // Finishing beat frees the slot in the same cycle, so masks chain without a bubble.
        ready  = (state_q == IDLE) | (beat & last);
        accept = bus.in_valid & ready;

        state_d = state_q;
        rem_d   = rem_q;
        zero_d  = zero_q;

        if (beat) begin
            if (enc_v) begin
                rem_d[enc_idx] = 1'b0;
            end
            if (last) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            rem_d   = bus.in_mask;
            zero_d  = (bus.in_mask == '0);
            state_d = EMIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
        end
    end

    // Encoder reports all ones on an empty mask; force index 0 there.
    assign bus.out_valid = emit;
    assign bus.out_idx   = (emit & enc_v) ? enc_idx : '0;
    assign bus.out_last  = last;
    assign bus.out_zero  = emit & zero_q;
    assign bus.in_ready  = ready;

endmodule

// File: tb/tb_ffo_index_streamer.sv
// tb_ffo_index_streamer: directed and randomized checks of ffo_index_streamer
// against a queue-based model of the expected index beats.
module tb_ffo_index_streamer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ffo_index_streamer_if #(.N(32)) bus ();

    ffo_index_streamer #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int idx;
        bit last;
        bit zero;
        int cyc;
    } beat_t;

    beat_t q[$];        // beats the model still owes
    beat_t obs[$];      // beats the DUT actually delivered
    int    exp_idx[$];
    bit    exp_last[$];

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int or_mode = 0;    // 0: out_ready=1, 1: toggle, 2: random

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail(input string name, input int got, input int exp);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Expected beats for one accepted mask, straight from the ordering rule.
    function automatic void expand(input logic [0:31] m);
        beat_t b;
        int    cnt;
        int    k;
        b.cyc = 0;
        if (m == '0) begin
            b.idx  = 0;
            b.last = 1'b1;
            b.zero = 1'b1;
            q.push_back(b);
        end else begin
            cnt = $countones(m);
            k   = 0;
            for (int i = 0; i < 32; i++) begin
                if (m[i]) begin
                    k++;
                    b.idx  = i;
                    b.last = (k == cnt);
                    b.zero = 1'b0;
                    q.push_back(b);
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Per-cycle compare and model update, sampled mid-cycle.
    bit    m_ev, m_er, m_beat, m_acc;
    beat_t m_ob;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
            chk("rst_out_idx",   32'(bus.out_idx),   32'd0);
            chk("rst_out_last",  32'(bus.out_last),  32'd0);
            chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
            q.delete();
        end else begin
            m_ev = (q.size() != 0);
            chk("out_valid", 32'(bus.out_valid), 32'(m_ev));
            m_er = !m_ev || (bus.out_ready && q[0].last);
            chk("in_ready", 32'(bus.in_ready), 32'(m_er));
            if (m_ev) begin
                chk("out_idx",  32'(bus.out_idx),  32'(q[0].idx));
                chk("out_last", 32'(bus.out_last), 32'(q[0].last));
                chk("out_zero", 32'(bus.out_zero), 32'(q[0].zero));
            end
            m_beat = m_ev && bus.out_ready;
            m_acc  = bus.in_valid && m_er;
            if (m_beat) begin
                m_ob.idx  = int'(bus.out_idx);
                m_ob.last = bus.out_last;
                m_ob.zero = bus.out_zero;
                m_ob.cyc  = cyc;
                obs.push_back(m_ob);
                void'(q.pop_front());
            end
            if (m_acc) begin
                expand(bus.in_mask);
            end
            cyc++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic offer(input logic [0:31] m, input bit keep, output int waited);
        bit acc;
        acc          = 1'b0;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_mask  = m;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            waited++;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) fail("offer_timeout", waited, 400);
        if (!keep || !acc) begin
            bus.in_valid = 1'b0;
            bus.in_mask  = $urandom;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input int idx, input bit last);
        exp_idx.push_back(idx);
        exp_last.push_back(last);
    endtask

    // Hand-written expectations for a directed case.
    task automatic check_seq(input string name, input bit zero_exp, input bit gapless);
        chk({name, "_count"}, 32'(obs.size()), 32'(exp_idx.size()));
        for (int i = 0; i < exp_idx.size(); i++) begin
            if (i < obs.size()) begin
                chk({name, "_idx"},  32'(obs[i].idx),  32'(exp_idx[i]));
                chk({name, "_last"}, 32'(obs[i].last), 32'(exp_last[i]));
                chk({name, "_zero"}, 32'(obs[i].zero), 32'(zero_exp));
                if (gapless && i > 0) begin
                    chk({name, "_gap"}, 32'(obs[i].cyc - obs[i-1].cyc), 32'd1);
                end
            end
        end
        exp_idx.delete();
        exp_last.delete();
        obs.delete();
    endtask

    initial begin
        int          w;
        logic [0:31] m;

        bus.in_valid = 1'b0;
        bus.in_mask  = '0;
        or_mode      = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // bits 0 and 31
        obs.delete();
        offer(32'h8000_0001, 1'b0, w);
        drain();
        ex(0, 1'b0);
        ex(31, 1'b1);
        check_seq("two_bits", 1'b0, 1'b1);
        chk("two_bits_in_ready_after", 32'(bus.in_ready),  32'd1);
        chk("two_bits_idle_after",     32'(bus.out_valid), 32'd0);

        // all-zero mask
        offer(32'h0000_0000, 1'b0, w);
        drain();
        ex(0, 1'b1);
        check_seq("zero_mask", 1'b1, 1'b1);
        chk("zero_mask_idle_after", 32'(bus.out_valid), 32'd0);

        // all ones
        offer(32'hFFFF_FFFF, 1'b0, w);
        drain();
        for (int i = 0; i < 32; i++) ex(i, (i == 31));
        check_seq("all_ones", 1'b0, 1'b1);

        // back-to-back masks
        offer(32'h0000_0003, 1'b1, w);
        offer(32'h4000_0000, 1'b0, w);
        chk("b2b_second_wait", 32'(w), 32'd2);
        drain();
        ex(30, 1'b0);
        ex(31, 1'b1);
        ex(1, 1'b1);
        check_seq("back_to_back", 1'b0, 1'b1);

        // backpressure with toggling out_ready
        or_mode = 1;
        offer(32'h0010_0800, 1'b0, w);
        drain();
        or_mode = 0;
        ex(11, 1'b0);
        ex(20, 1'b1);
        check_seq("backpressure", 1'b0, 1'b0);

        // reset pulsed during the first beat
        @(posedge clk);
        #1;
        obs.delete();
        offer(32'h0700_0000, 1'b0, w);
        #2;
        chk("mid_rst_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_rst_pre_idx",   32'(bus.out_idx),   32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_async_ready", 32'(bus.in_ready),  32'd1);
        chk("mid_rst_async_idx",   32'(bus.out_idx),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs.delete();
        offer(32'h0000_0001, 1'b0, w);
        chk("post_rst_accept_wait", 32'(w), 32'd1);
        drain();
        ex(31, 1'b1);
        check_seq("post_rst", 1'b0, 1'b1);

        // randomized masks, offer gaps and backpressure
        or_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_mask = $urandom;
                @(posedge clk);
                #1;
            end else begin
                case ($urandom_range(0, 3))
                    0: m = '0;
                    1: begin
                        m = '0;
                        m[$urandom_range(0, 31)] = 1'b1;
                    end
                    2: m = $urandom & $urandom & $urandom;
                    default: m = $urandom;
                endcase
                offer(m, 1'b0, w);
            end
        end
        or_mode = 0;
        drain();
        chk("final_idle", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule

// File: doc/ffo_index_streamer.md
# ffo_index_streamer

Sequential find-first-one serializer. It accepts an N-bit request mask over a valid/ready handshake and emits, one beat per cycle, the index of every set bit in priority order, clearing each bit as it is consumed. It is the consumer-side counterpart of the combinational leading-one detector tree: that tree yields a single first index, and this block walks the whole mask. It sits between request-collection logic (arbiters, pending-interrupt registers) and downstream units that service one index at a time.

## Interface
- N, 32, mask width; power of two, at least 4
- IDX_W, $clog2(N), index width (derived; do not override)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  mask offered
- in_ready  out  1  block can accept a mask
- in_mask  in  [0:N-1]  request mask; bit 0 is leftmost and has highest priority
- out_valid  out  1  index beat valid
- out_ready  in  1  downstream accepts beat
- out_idx  out  [0:IDX_W-1]  index of the current first set bit, bit 0 = index MSB
- out_last  out  1  final beat for this mask
- out_zero  out  1  accepted mask was all-zero (single beat, out_idx=0)

## Operation
- State register with values IDLE and EMIT; mask register rem[0:N-1]; flag zero_q.
- IDLE: in_ready=1, out_valid=0. On in_valid: rem<=in_mask, zero_q<=(in_mask==0), go to EMIT.
- EMIT: out_valid=1. out_idx is the encoder output of rem, out_zero=zero_q, and out_last = zero_q | (rem has exactly one bit set).
- Beat handshake (out_valid & out_ready) clears rem[out_idx].
  - If out_last: in_ready=1 this cycle. If in_valid is also high, load the new mask and stay in EMIT (back-to-back, no bubble); otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). It depends combinationally on out_ready and never depends on in_valid.
- Order: ascending index, i.e. leftmost set bit first.
- All-zero mask: produces exactly one beat with out_zero=1, out_last=1, out_idx=0.
- Stall: while out_valid & ~out_ready, out_idx, out_last and out_zero hold stable. in_mask is ignored while in_ready=0.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, rem=0, zero_q=0. This gives out_valid=0, out_idx=0, out_last=0, out_zero=0, in_ready=1.
- Latency: mask accepted at edge t, so first out_valid is high in cycle t+1.
- Throughput: one index per cycle with out_ready held high. A mask with K set bits occupies K cycles (1 cycle if K=0). The next mask's first beat follows the last beat with no gap.
- Reset asserted mid-mask: remaining indices are discarded and out_valid falls without waiting for a clock edge. The first accept is allowed on the first clk edge after rst_n deasserts.
- out_idx path: rem register, then the encoder (log2 N merge levels), then the output port. No combinational path from in_* to out_*.

## Structure
- Package ffo_pkg holds:
  - default N
  - state enum (IDLE, EMIT)
  - function onehot_count_le1 (true when at most one bit is set)
- Sub-module ffo_prio_enc (parameter N, mask[0:N-1] in, v and idx[0:IDX_W-1] out):
  - purely combinational, built as a binary tree of two-input merge nodes
  - merge rule: v = v0|v1; idx MSB = ~v0; remaining bits taken from the left child when v0=1, otherwise from the right child
- Top level holds only the FSM, rem, zero_q and the handshake logic.

## Test plan
- Reset, then offer in_mask=32'h8000_0001 (bits 0 and 31) with out_ready=1 → out_idx=0 (last=0), then 31 (last=1), then in_ready high.
- in_mask=0 → one beat with out_zero=1, out_last=1, out_idx=0; then IDLE.
- in_mask=32'hFFFF_FFFF with out_ready=1 → indices 0..31 in 32 consecutive cycles; last only on 31.
- Back-to-back: mask 32'h0000_0003 then 32'h4000_0000 held on in_valid → beats 30, 31, 1 with no idle cycle; second mask accepted on the beat with index 31.
- Backpressure: mask 32'h0010_0800, out_ready toggled 0/1 each cycle → out_idx holds 11 until accepted, then 20; no beat lost or duplicated.
- rst_n pulsed low during the beat with index 5 of mask 32'h0700_0000 → out_valid falls immediately; after release, in_ready=1 and a fresh mask 32'h0000_0001 yields only index 31.
